// File: rtl/bht_update_buffer_pkg.sv
// Shared types for the commit-gated BHT update buffer: core config subset,
// address width and the update record sent to the branch history table.
package bht_update_buffer_pkg;

  localparam int unsigned VLEN = 32;

  typedef struct packed {
    logic DebugEn;
  } cfg_t;

  localparam cfg_t cva6_cfg_empty = '{DebugEn: 1'b0};

  typedef struct packed {
    logic            valid;
    logic [VLEN-1:0] pc;
    logic            taken;
  } bht_update_t;

  localparam int unsigned BHT_UPD_W = $bits(bht_update_t);

endpackage

// File: rtl/bht_update_buffer.sv
// Holds speculative branch resolutions in program order and releases one BHT
// update per committed branch; uncommitted entries are dropped on flush.
module bht_update_buffer
  import bht_update_buffer_pkg::*;
#(
  parameter cfg_t        CVA6Cfg       = cva6_cfg_empty,
  parameter int unsigned DEPTH         = 4,
  parameter int unsigned TRANS_ID_BITS = 3
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         flush_i,
  input  logic                         debug_mode_i,
  input  logic                         resolve_valid_i,
  input  logic [VLEN-1:0]              resolve_pc_i,
  input  logic                         resolve_taken_i,
  input  logic [TRANS_ID_BITS-1:0]     resolve_trans_id_i,
  input  logic                         commit_valid_i,
  input  logic [TRANS_ID_BITS-1:0]     commit_trans_id_i,
  output logic [BHT_UPD_W-1:0]         bht_update_o,
  output logic                         overflow_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);

  typedef struct packed {
    logic                     valid;
    logic                     committed;
    logic [TRANS_ID_BITS-1:0] trans_id;
    logic [VLEN-1:0]          pc;
    logic                     taken;
  } bht_upd_entry_t;

  bht_upd_entry_t [DEPTH-1:0] mem_q, mem_d;
  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;

  logic        pop, full, push, upd_valid;
  logic [CW-1:0] kept;
  bht_update_t upd;

  assign pop  = mem_q[head_q].valid & mem_q[head_q].committed;
  assign full = (count_q == CW'(DEPTH));
  assign push = resolve_valid_i & ~flush_i & (~full | pop);

  always_comb begin
    mem_d      = mem_q;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    overflow_d = 1'b0;
    kept       = '0;

    for (int i = 0; i < DEPTH; i++) begin
      if (commit_valid_i && mem_q[i].valid && mem_q[i].trans_id == commit_trans_id_i)
        mem_d[i].committed = 1'b1;
    end

    if (pop) begin
      mem_d[head_q] = '0;
      head_d        = head_q + PW'(1);
    end

    if (flush_i) begin
      // Surviving entries are the committed ones, contiguous from the new head.
      for (int i = 0; i < DEPTH; i++) begin
        if (!mem_d[i].committed) mem_d[i] = '0;
        else                     kept = kept + CW'(1);
      end
      tail_d  = head_d + kept[PW-1:0];
      count_d = kept;
    end else begin
      if (push) begin
        mem_d[tail_q].valid     = 1'b1;
        mem_d[tail_q].committed = commit_valid_i && (commit_trans_id_i == resolve_trans_id_i);
        mem_d[tail_q].trans_id  = resolve_trans_id_i;
        mem_d[tail_q].pc        = resolve_pc_i;
        mem_d[tail_q].taken     = resolve_taken_i;
        tail_d                  = tail_q + PW'(1);
      end
      overflow_d = resolve_valid_i & full & ~pop;
      count_d    = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mem_q      <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      mem_q      <= mem_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Debug mode still pops the head, it just never trains the predictor.
  assign upd_valid = pop & ~(CVA6Cfg.DebugEn & debug_mode_i);

  always_comb begin
    upd = '0;
    if (upd_valid) begin
      upd.valid = 1'b1;
      upd.pc    = mem_q[head_q].pc;
      upd.taken = mem_q[head_q].taken;
    end
  end

  assign bht_update_o = upd;
  assign overflow_o   = overflow_q;
  assign count_o      = count_q;

endmodule
